// File: rtl/disp7_load_if.sv
// Valid/ready load channel carrying one display word (nibbles plus per-digit blank mask).
interface disp7_load_if #(
  parameter int N_DIG = 4
);
  logic                 load_valid;
  logic                 load_ready;
  logic [4*N_DIG-1:0]   load_data;
  logic [N_DIG-1:0]     load_blank;

  modport master (output load_valid, load_data, load_blank, input load_ready);
  modport slave  (input load_valid, load_data, load_blank, output load_ready);
endinterface

// File: rtl/disp7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: per-slot ghost blanking, one-hot digit
// enables, and a double-buffered display word that only changes at frame boundaries.
module disp7_scan_ctrl #(
  parameter int N_DIG     = 4,
  parameter int SLOT_CYC  = 1000,
  parameter int BLANK_CYC = 50,
  parameter int CW        = $clog2(SLOT_CYC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  disp7_load_if.slave       ld,
  output logic [3:0]        nib_out,
  output logic [N_DIG-1:0]  dig_en,
  output logic              frame_done
);

  localparam int            IW        = $clog2(N_DIG);
  localparam logic [CW-1:0] LAST_CNT  = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_DIG - 1);
  localparam logic [N_DIG-1:0] ONE    = N_DIG'(1);

  typedef enum logic [1:0] {S_OFF, S_BLANK, S_ON} state_t;

  state_t               r_state, w_state_next;
  logic [IW-1:0]        r_idx, w_idx_next;
  logic [CW-1:0]        r_cnt, w_cnt_next;

  logic [4*N_DIG-1:0]   r_act_data, r_pend_data, w_act_data_next;
  logic [N_DIG-1:0]     r_act_blank, r_pend_blank, w_act_blank_next;
  logic                 r_pending, w_pending_next;
  logic                 r_load_ready;

  logic [3:0]           r_nib, w_nib_next;
  logic [N_DIG-1:0]     r_dig_en, w_dig_next;
  logic                 r_frame_done, w_fd_next;

  logic                 w_xfer, w_promote;
  logic [3:0]           w_nib_arr [N_DIG];

  // The word taking effect this edge must drive the outputs registered on the same edge.
  assign w_xfer           = ld.load_valid && !r_pending;
  assign w_promote        = r_pending && (r_frame_done || (r_state == S_OFF) || !en);
  assign w_pending_next   = w_xfer ? 1'b1 : (w_promote ? 1'b0 : r_pending);
  assign w_act_data_next  = w_promote ? r_pend_data  : r_act_data;
  assign w_act_blank_next = w_promote ? r_pend_blank : r_act_blank;

  genvar gi;
  generate
    for (gi = 0; gi < N_DIG; gi++) begin : g_nib
      assign w_nib_arr[gi] = w_act_data_next[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_cnt_next   = r_cnt;
    if (!en) begin
      w_state_next = S_OFF;
      w_idx_next   = '0;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state_next = (BLANK_CYC == 0) ? S_ON : S_BLANK;
          w_idx_next   = '0;
          w_cnt_next   = '0;
        end
        S_BLANK: begin
          w_cnt_next = r_cnt + CW'(1);
          if (r_cnt == BLANK_END) w_state_next = S_ON;
        end
        S_ON: begin
          if (r_cnt == LAST_CNT) begin
            w_cnt_next   = '0;
            w_idx_next   = (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
            w_state_next = (BLANK_CYC == 0) ? S_ON : S_BLANK;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_next = S_OFF;
          w_idx_next   = '0;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_nib_next = '0;
    w_dig_next = '0;
    w_fd_next  = 1'b0;
    if (w_state_next != S_OFF) w_nib_next = w_nib_arr[w_idx_next];
    if (w_state_next == S_ON && !w_act_blank_next[w_idx_next]) w_dig_next = ONE << w_idx_next;
    if (w_state_next == S_ON && w_idx_next == LAST_IDX && w_cnt_next == LAST_CNT) w_fd_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_OFF;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_act_data   <= '0;
      r_act_blank  <= '1;
      r_pend_data  <= '0;
      r_pend_blank <= '0;
      r_pending    <= 1'b0;
      r_load_ready <= 1'b1;
      r_nib        <= '0;
      r_dig_en     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_cnt        <= w_cnt_next;
      r_act_data   <= w_act_data_next;
      r_act_blank  <= w_act_blank_next;
      if (w_xfer) begin
        r_pend_data  <= ld.load_data;
        r_pend_blank <= ld.load_blank;
      end
      r_pending    <= w_pending_next;
      r_load_ready <= !w_pending_next;
      r_nib        <= w_nib_next;
      r_dig_en     <= w_dig_next;
      r_frame_done <= w_fd_next;
    end
  end

  assign ld.load_ready = r_load_ready;
  assign nib_out       = r_nib;
  assign dig_en        = r_dig_en;
  assign frame_done    = r_frame_done;

endmodule
